coeff_dequant_writer: RTL and testbench

- Upstream neighbour of the IDCT stage: consumes quantized 8x8 coefficient blocks arriving in zig-zag order from the lossless decoder.
- Dequantizes each coefficient by a power-of-two shift and reorders the block to raster order.
- Writes the result as 16-bit words into the pre-IDCT SRAM region (76800..230399), in the block layout the IDCT fetch reads.

---
 rtl/coeff_dequant_writer_if.sv | 23 ++
 rtl/coeff_dequant_writer.sv | 278 +++++++++++++++++++++++++++
 tb/tb_coeff_dequant_writer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coeff_dequant_writer_if.sv
// coeff_dequant_writer_if: coefficient stream, SRAM write port and status of the
// coefficient dequantizer/writer. master = upstream/observer side, slave = the writer.
interface coeff_dequant_writer_if;
  logic signed [15:0] coeff_in;
  logic               coeff_valid;
  logic               coeff_ready;
  logic               q_sel;
  logic        [17:0] SRAM_address;
  logic        [15:0] SRAM_write_data;
  logic               SRAM_we_n;
  logic               block_done;
  logic               done;

  modport master (
    output coeff_in, coeff_valid, q_sel,
    input  coeff_ready, SRAM_address, SRAM_write_data, SRAM_we_n, block_done, done
  );

  modport slave (
    input  coeff_in, coeff_valid, q_sel,
    output coeff_ready, SRAM_address, SRAM_write_data, SRAM_we_n, block_done, done
  );
endinterface

// File: rtl/coeff_dequant_writer.sv
// coeff_dequant_writer: dequantizes zig-zag ordered 8x8 coefficient blocks by a
// power-of-two shift, reorders them to raster order and writes them as 16-bit words
// into the pre-IDCT SRAM region (Y, then U, then V segment).
// Optional macro DEQ_PINGPONG_EN: two block buffers so accepting the next block
// overlaps the SRAM drain of the previous one.
module coeff_dequant_writer #(
  parameter logic [17:0] PREIDCT_BASE = 18'd76800,
  parameter logic [17:0] U_SEG_BASE   = 18'd153600,
  parameter logic [17:0] V_SEG_BASE   = 18'd192000,
  parameter int unsigned Y_BLOCKS     = 1200,
  parameter int unsigned UV_BLOCKS    = 600
) (
  input logic                   Clock,
  input logic                   Resetn,
  input logic                   Enable,
  coeff_dequant_writer_if.slave bus
);
  localparam logic [4:0] YLastRow  = 5'(Y_BLOCKS / 40 - 1);
  localparam logic [4:0] UvLastRow = 5'(UV_BLOCKS / 20 - 1);

  // Zig-zag position -> raster index.
  localparam logic [5:0] Zz2Raster [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

`ifdef DEQ_PINGPONG_EN
  localparam int unsigned IdxW = 7;
`else
  localparam int unsigned IdxW = 6;
`endif

  typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;
  state_e state_q, state_d;

  logic [5:0]  k_q, k_d, n_q, n_d;
  logic        q_lat_q, q_lat_d;
  logic [1:0]  seg_q, seg_d;
  logic [4:0]  brow_q, brow_d;
  logic [5:0]  bcol_q, bcol_d;
  logic        we_n_q, we_n_d, bdone_q, bdone_d, done_q, done_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] buf_q [1 << IdxW];

  logic             ready, xfer, fill_done, start, drain, blk_end;
  logic             last_col, last_row, last_blk, other_full;
  logic [5:0]       raster;
  logic [3:0]       diag;
  logic             q_cur;
  logic [2:0]       shamt;
  logic signed [23:0] wide;
  logic [15:0]      deq;
  logic [17:0]      seg_base, line_w, addr_wr;
  logic [IdxW-1:0]  wr_idx, rd_idx;

  assign xfer      = bus.coeff_valid && ready;
  assign fill_done = xfer && (k_q == 6'd63);
  assign start     = Enable && (state_q == StIdle || state_q == StDone);
  assign drain     = (state_q == StWrite);
  assign blk_end   = drain && (n_q == 6'd63);
  assign last_col  = (seg_q == 2'd0) ? (bcol_q == 6'd39) : (bcol_q == 6'd19);
  assign last_row  = (seg_q == 2'd0) ? (brow_q == YLastRow) : (brow_q == UvLastRow);
  assign last_blk  = (seg_q == 2'd2) && last_row && last_col;

`ifdef DEQ_PINGPONG_EN
  logic       fsel_q, fsel_d, dsel_q, dsel_d;
  logic [1:0] full_q, full_d;
  // A drain may chain straight into the other buffer if it is full or fills now.
  assign other_full = full_q[~dsel_q] || fill_done;
  assign wr_idx     = {fsel_q, raster};
  assign rd_idx     = {dsel_q, n_q};
`else
  assign other_full = 1'b0;
  assign wr_idx     = raster;
  assign rd_idx     = n_q;
`endif

  // Dequantize the incoming coefficient: shift by diagonal class, then saturate.
  always_comb begin
    raster = Zz2Raster[k_q];
    diag   = {1'b0, raster[5:3]} + {1'b0, raster[2:0]};
    // q_sel is taken live on k=0 so the whole block uses the same matrix.
    q_cur  = (k_q == 6'd0) ? bus.q_sel : q_lat_q;
    if (!q_cur) begin
      if (diag == 4'd0)      shamt = 3'd3;
      else if (diag == 4'd1) shamt = 3'd2;
      else if (diag <= 4'd3) shamt = 3'd3;
      else if (diag <= 4'd5) shamt = 3'd4;
      else if (diag <= 4'd7) shamt = 3'd5;
      else                   shamt = 3'd6;
    end else begin
      if (diag == 4'd0)      shamt = 3'd3;
      else if (diag <= 4'd3) shamt = 3'd1;
      else if (diag <= 4'd5) shamt = 3'd2;
      else if (diag <= 4'd7) shamt = 3'd3;
      else                   shamt = 3'd4;
    end
    wide = {{8{bus.coeff_in[15]}}, bus.coeff_in};
    wide = wide <<< shamt;
    if (wide > 24'sd32767)       deq = 16'h7FFF;
    else if (wide < -24'sd32768) deq = 16'h8000;
    else                         deq = wide[15:0];
  end

  // SRAM address of raster word n_q in the current block.
  always_comb begin
    case (seg_q)
      2'd1:    begin seg_base = U_SEG_BASE;   line_w = 18'd160; end
      2'd2:    begin seg_base = V_SEG_BASE;   line_w = 18'd160; end
      default: begin seg_base = PREIDCT_BASE; line_w = 18'd320; end
    endcase
    addr_wr = seg_base + 18'(brow_q) * (line_w << 3) + 18'({bcol_q, 3'b000})
              + 18'(n_q[5:3]) * line_w + 18'(n_q[2:0]);
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (Enable) state_d = StAccept;
      StAccept: if (fill_done) state_d = StWrite;
      StWrite:  if (n_q == 6'd63) begin
        if (last_blk)        state_d = StDone;
        else if (other_full) state_d = StWrite;
        else                 state_d = StAccept;
      end
      StDone:   if (Enable) state_d = StAccept;
    endcase
  end

  // FSM outputs: handshake and next values of the registered SRAM port.
  always_comb begin
    ready   = 1'b0;
    we_n_d  = 1'b1;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bdone_d = 1'b0;
    done_d  = done_q;
    unique case (state_q)
      StIdle: ;
      StAccept: begin
`ifdef DEQ_PINGPONG_EN
        ready = !full_q[fsel_q];
`else
        ready = 1'b1;
`endif
      end
      StWrite: begin
`ifdef DEQ_PINGPONG_EN
        ready = !full_q[fsel_q];
`endif
        we_n_d  = 1'b0;
        addr_d  = addr_wr;
        wdata_d = buf_q[rd_idx];
        bdone_d = (n_q == 6'd63);
      end
      StDone: done_d = 1'b1;
    endcase
    if (start) done_d = 1'b0;
  end

  assign bus.coeff_ready     = ready;
  assign bus.SRAM_address    = addr_q;
  assign bus.SRAM_write_data = wdata_q;
  assign bus.SRAM_we_n       = we_n_q;
  assign bus.block_done      = bdone_q;
  assign bus.done            = done_q;

  // Datapath next state: coefficient index, write index, block position.
  always_comb begin
    k_d     = k_q;
    n_d     = n_q;
    q_lat_d = q_lat_q;
    seg_d   = seg_q;
    brow_d  = brow_q;
    bcol_d  = bcol_q;
    if (xfer) begin
      k_d = k_q + 6'd1;
      if (k_q == 6'd0) q_lat_d = bus.q_sel;
    end
    if (drain) n_d = n_q + 6'd1;
    if (blk_end && !last_blk) begin
      if (last_col) begin
        bcol_d = 6'd0;
        if (last_row) begin
          brow_d = 5'd0;
          seg_d  = seg_q + 2'd1;
        end else begin
          brow_d = brow_q + 5'd1;
        end
      end else begin
        bcol_d = bcol_q + 6'd1;
      end
    end
    if (start) begin
      k_d    = 6'd0;
      n_d    = 6'd0;
      seg_d  = 2'd0;
      brow_d = 5'd0;
      bcol_d = 6'd0;
    end
`ifdef DEQ_PINGPONG_EN
    fsel_d = fsel_q;
    dsel_d = dsel_q;
    full_d = full_q;
    if (blk_end) begin
      full_d[dsel_q] = 1'b0;
      dsel_d         = ~dsel_q;
    end
    if (fill_done) begin
      full_d[fsel_q] = 1'b1;
      fsel_d         = ~fsel_q;
    end
    if (start) begin
      fsel_d = 1'b0;
      dsel_d = 1'b0;
      full_d = 2'b00;
    end
`endif
  end

  // Datapath and output registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      k_q     <= 6'd0;
      n_q     <= 6'd0;
      q_lat_q <= 1'b0;
      seg_q   <= 2'd0;
      brow_q  <= 5'd0;
      bcol_q  <= 6'd0;
      we_n_q  <= 1'b1;
      addr_q  <= 18'd0;
      wdata_q <= 16'd0;
      bdone_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef DEQ_PINGPONG_EN
      fsel_q  <= 1'b0;
      dsel_q  <= 1'b0;
      full_q  <= 2'b00;
`endif
    end else begin
      k_q     <= k_d;
      n_q     <= n_d;
      q_lat_q <= q_lat_d;
      seg_q   <= seg_d;
      brow_q  <= brow_d;
      bcol_q  <= bcol_d;
      we_n_q  <= we_n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bdone_q <= bdone_d;
      done_q  <= done_d;
`ifdef DEQ_PINGPONG_EN
      fsel_q  <= fsel_d;
      dsel_q  <= dsel_d;
      full_q  <= full_d;
`endif
    end
  end

  // Block buffer; every entry is rewritten before it is drained, so no reset.
  always_ff @(posedge Clock) begin
    if (xfer) buf_q[wr_idx] <= deq;
  end
endmodule

// File: tb/tb_coeff_dequant_writer.sv
// Directed bench for coeff_dequant_writer: a full-size instance plus a reduced
// instance (1 block row per segment) to reach the segment boundaries quickly.
module tb_coeff_dequant_writer;
  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic signed [15:0] c_in;
  logic c_valid, c_qsel;

  always #5 clk = ~clk;

  coeff_dequant_writer_if bus_m ();
  coeff_dequant_writer_if bus_s ();

  assign bus_m.coeff_in = c_in;
  assign bus_m.coeff_valid = c_valid;
  assign bus_m.q_sel = c_qsel;
  assign bus_s.coeff_in = c_in;
  assign bus_s.coeff_valid = c_valid;
  assign bus_s.q_sel = c_qsel;

  coeff_dequant_writer u_dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .Enable (enable),
    .bus    (bus_m)
  );

  coeff_dequant_writer #(
    .Y_BLOCKS  (40),
    .UV_BLOCKS (20)
  ) u_dut_small (
    .Clock  (clk),
    .Resetn (rst_n),
    .Enable (enable),
    .bus    (bus_s)
  );

  int n_checks = 0;
  int n_fail = 0;
  int early_cnt = 0;
  int bd_cnt_m = 0;
  logic [17:0] wr_addr_m [$];
  logic [15:0] wr_data_m [$];
  logic [17:0] wr_addr_s [$];
  logic signed [15:0] vals [64];
  logic [15:0] exp_d [64];

  // Write monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus_m.SRAM_we_n === 1'b0) begin
      wr_addr_m.push_back(bus_m.SRAM_address);
      wr_data_m.push_back(bus_m.SRAM_write_data);
    end
    if (bus_m.block_done === 1'b1) bd_cnt_m++;
    if (bus_s.SRAM_we_n === 1'b0) wr_addr_s.push_back(bus_s.SRAM_address);
  end

  task automatic clear_vals();
    for (int i = 0; i < 64; i++) begin
      vals[i] = 16'sd0;
      exp_d[i] = 16'h0000;
    end
  endtask

  task automatic start_run();
    c_valid = 1'b0;
    enable = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
  endtask

  // Sends vals[0..nx-1]; stall toggles valid every cycle; q_sel inverts from flip_k on.
  task automatic send_block(input int nx, input bit stall, input logic q0, input int flip_k,
                            output bit ok);
    int k = 0;
    int cyc = 0;
    bit xfer;
    while (k < nx && cyc < 4000) begin
      c_valid = (!stall || (cyc % 2 == 0));
      c_in = c_valid ? vals[k] : 16'sh5A5A;
      c_qsel = (k >= flip_k) ? ~q0 : q0;
      if (bus_m.SRAM_we_n === 1'b0) early_cnt++;
      xfer = c_valid && (bus_m.coeff_ready === 1'b1);
      @(posedge clk);
      #1;
      if (xfer) k++;
      cyc++;
    end
    c_valid = 1'b0;
    c_in = 16'sd0;
    ok = (k == nx);
  endtask

  task automatic wait_writes(input int target, output bit ok);
    int g = 0;
    while (wr_addr_m.size() < target && g < 20000) begin
      @(posedge clk);
      #1;
      g++;
    end
    ok = (wr_addr_m.size() >= target);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    enable = 1'b0;
    c_valid = 1'b0;
    c_in = 16'sd0;
    c_qsel = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_m.coeff_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got %b want 0", bus_m.coeff_ready);
    end
    n_checks++;
    if (bus_m.SRAM_we_n !== 1'b1) begin
      n_fail++; $display("FAIL reset_we_n got %b want 1", bus_m.SRAM_we_n);
    end
    n_checks++;
    if (bus_m.SRAM_address !== 18'd0 || bus_m.SRAM_write_data !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_addr_data got %0d/%h want 0/0", bus_m.SRAM_address,
               bus_m.SRAM_write_data);
    end
    n_checks++;
    if (bus_m.block_done !== 1'b0 || bus_m.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got %b%b want 00", bus_m.block_done, bus_m.done);
    end
  endtask

  task automatic test_dequant_q0();
    int base;
    int bd0;
    bit ok, ok2;
    logic [17:0] ea;
    start_run();
    clear_vals();
    vals[0] = 16'sd5; vals[1] = -16'sd3; vals[2] = 16'sd1;
    exp_d[0] = 16'h0028; exp_d[1] = 16'hFFF4; exp_d[8] = 16'h0004;
    base = wr_addr_m.size();
    bd0 = bd_cnt_m;
    send_block(64, 1'b0, 1'b0, 64, ok);
    n_checks++;
    if (bus_m.SRAM_we_n !== 1'b1) begin
      n_fail++; $display("FAIL q0_latency_early got we_n=%b want 1", bus_m.SRAM_we_n);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_m.SRAM_we_n !== 1'b0 || bus_m.SRAM_address !== 18'd76800) begin
      n_fail++;
      $display("FAIL q0_first_write got we_n=%b addr=%0d want 0/76800", bus_m.SRAM_we_n,
               bus_m.SRAM_address);
    end
    wait_writes(base + 64, ok2);
    n_checks++;
    if (!(ok && ok2)) begin
      n_fail++; $display("FAIL q0_timeout got %b%b want 11", ok, ok2);
    end
    for (int n = 0; n < 64; n++) begin
      ea = 18'(76800 + (n / 8) * 320 + n % 8);
      n_checks++;
      if (wr_addr_m[base+n] !== ea || wr_data_m[base+n] !== exp_d[n]) begin
        n_fail++;
        $display("FAIL q0_word%0d got %0d:%h want %0d:%h", n, wr_addr_m[base+n],
                 wr_data_m[base+n], ea, exp_d[n]);
      end
    end
    n_checks++;
    if (bd_cnt_m - bd0 !== 1) begin
      n_fail++; $display("FAIL q0_block_done got %0d want 1", bd_cnt_m - bd0);
    end
  endtask

  task automatic test_q1();
    int base;
    bit ok, ok2;
    start_run();
    clear_vals();
    vals[1] = 16'sd1; vals[63] = 16'sd2;
    exp_d[1] = 16'h0002; exp_d[63] = 16'h0020;
    base = wr_addr_m.size();
    send_block(64, 1'b0, 1'b1, 64, ok);
    wait_writes(base + 64, ok2);
    n_checks++;
    if (!(ok && ok2)) begin
      n_fail++; $display("FAIL q1_timeout got %b%b want 11", ok, ok2);
    end
    n_checks++;
    if (wr_addr_m[base+63] !== 18'd79047) begin
      n_fail++; $display("FAIL q1_addr63 got %0d want 79047", wr_addr_m[base+63]);
    end
    for (int n = 0; n < 64; n++) begin
      n_checks++;
      if (wr_data_m[base+n] !== exp_d[n]) begin
        n_fail++; $display("FAIL q1_word%0d got %h want %h", n, wr_data_m[base+n], exp_d[n]);
      end
    end
  endtask

  task automatic test_saturation();
    int base;
    bit ok, ok1, ok2;
    start_run();
    clear_vals();
    base = wr_addr_m.size();
    vals[0] = 16'sd5000;
    send_block(64, 1'b0, 1'b0, 64, ok);
    vals[0] = -16'sd5000;
    send_block(64, 1'b0, 1'b0, 64, ok1);
    wait_writes(base + 128, ok2);
    n_checks++;
    if (!(ok && ok1 && ok2)) begin
      n_fail++; $display("FAIL sat_timeout got %b%b%b want 111", ok, ok1, ok2);
    end
    n_checks++;
    if (wr_addr_m[base] !== 18'd76800 || wr_data_m[base] !== 16'h7FFF) begin
      n_fail++;
      $display("FAIL sat_pos got %0d:%h want 76800:7fff", wr_addr_m[base], wr_data_m[base]);
    end
    n_checks++;
    if (wr_addr_m[base+64] !== 18'd76808 || wr_data_m[base+64] !== 16'h8000) begin
      n_fail++;
      $display("FAIL sat_neg got %0d:%h want 76808:8000", wr_addr_m[base+64],
               wr_data_m[base+64]);
    end
  endtask

  task automatic test_block_addressing();
    int base;
    int bd0;
    bit ok, ok_all, ok2;
    start_run();
    clear_vals();
    base = wr_addr_m.size();
    bd0 = bd_cnt_m;
    ok_all = 1'b1;
    for (int b = 0; b < 41; b++) begin
      send_block(64, 1'b0, 1'b0, 64, ok);
      ok_all = ok_all && ok;
    end
    wait_writes(base + 41 * 64, ok2);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (!(ok_all && ok2)) begin
      n_fail++; $display("FAIL addr_timeout got %b%b want 11", ok_all, ok2);
    end
    n_checks++;
    if (wr_addr_m[base+64] !== 18'd76808) begin
      n_fail++; $display("FAIL addr_blk1 got %0d want 76808", wr_addr_m[base+64]);
    end
    n_checks++;
    if (wr_addr_m[base+40*64] !== 18'd79360) begin
      n_fail++; $display("FAIL addr_blk40 got %0d want 79360", wr_addr_m[base+40*64]);
    end
    n_checks++;
    if (bd_cnt_m - bd0 !== 41 || wr_addr_m.size() - base !== 41 * 64) begin
      n_fail++;
      $display("FAIL addr_counts got bd=%0d wr=%0d want 41/2624", bd_cnt_m - bd0,
               wr_addr_m.size() - base);
    end
  endtask

  task automatic test_segments();
    int bs;
    int g;
    bit ok, ok_all;
    start_run();
    clear_vals();
    bs = wr_addr_s.size();
    ok_all = 1'b1;
    for (int b = 0; b < 80; b++) begin
      send_block(64, 1'b0, 1'b0, 64, ok);
      ok_all = ok_all && ok;
    end
    g = 0;
    while (wr_addr_s.size() < bs + 80 * 64 && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (!ok_all || wr_addr_s.size() - bs !== 80 * 64) begin
      n_fail++; $display("FAIL seg_count got %0d want 5120", wr_addr_s.size() - bs);
    end
    n_checks++;
    if (wr_addr_s[bs+39*64] !== 18'd77112) begin
      n_fail++; $display("FAIL seg_last_y got %0d want 77112", wr_addr_s[bs+39*64]);
    end
    n_checks++;
    if (wr_addr_s[bs+40*64] !== 18'd153600 || wr_addr_s[bs+40*64+8] !== 18'd153760) begin
      n_fail++;
      $display("FAIL seg_u got %0d/%0d want 153600/153760", wr_addr_s[bs+40*64],
               wr_addr_s[bs+40*64+8]);
    end
    n_checks++;
    if (wr_addr_s[bs+60*64] !== 18'd192000) begin
      n_fail++; $display("FAIL seg_v got %0d want 192000", wr_addr_s[bs+60*64]);
    end
    n_checks++;
    if (wr_addr_s[bs+80*64-1] !== 18'd193279) begin
      n_fail++; $display("FAIL seg_last got %0d want 193279", wr_addr_s[bs+80*64-1]);
    end
    n_checks++;
    if (bus_s.done !== 1'b1 || bus_s.SRAM_we_n !== 1'b1) begin
      n_fail++; $display("FAIL seg_done got %b/%b want 1/1", bus_s.done, bus_s.SRAM_we_n);
    end
    n_checks++;
    if (bus_m.done !== 1'b0) begin
      n_fail++; $display("FAIL seg_full_not_done got %b want 0", bus_m.done);
    end
  endtask

  task automatic test_backpressure();
    int base;
    bit ok, ok2;
    start_run();
    clear_vals();
    vals[0] = 16'sd7; vals[12] = 16'sd3; vals[30] = 16'sd100; vals[63] = -16'sd1;
    exp_d[0] = 16'h0038; exp_d[18] = 16'h0030; exp_d[21] = 16'h0C80; exp_d[63] = 16'hFFC0;
    base = wr_addr_m.size();
    early_cnt = 0;
    send_block(64, 1'b1, 1'b0, 10, ok);
    wait_writes(base + 64, ok2);
    n_checks++;
    if (!(ok && ok2) || early_cnt !== 0) begin
      n_fail++; $display("FAIL bp_early got ok=%b%b early=%0d want 11/0", ok, ok2, early_cnt);
    end
    for (int n = 0; n < 64; n++) begin
      n_checks++;
      if (wr_data_m[base+n] !== exp_d[n]) begin
        n_fail++; $display("FAIL bp_word%0d got %h want %h", n, wr_data_m[base+n], exp_d[n]);
      end
    end
  endtask

  task automatic test_reset_midblock();
    int base;
    bit ok, ok2;
    start_run();
    clear_vals();
    for (int i = 0; i < 64; i++) vals[i] = 16'sh0100;
    send_block(30, 1'b0, 1'b1, 64, ok);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_m.coeff_ready !== 1'b0 || bus_m.SRAM_we_n !== 1'b1 || bus_m.done !== 1'b0 ||
        bus_m.block_done !== 1'b0 || bus_m.SRAM_address !== 18'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs got rdy=%b we_n=%b done=%b bd=%b addr=%0d want 0/1/0/0/0",
               bus_m.coeff_ready, bus_m.SRAM_we_n, bus_m.done, bus_m.block_done,
               bus_m.SRAM_address);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    clear_vals();
    vals[0] = 16'sd5; vals[1] = -16'sd3; vals[2] = 16'sd1;
    exp_d[0] = 16'h0028; exp_d[1] = 16'hFFF4; exp_d[8] = 16'h0004;
    base = wr_addr_m.size();
    send_block(64, 1'b0, 1'b0, 64, ok);
    wait_writes(base + 64, ok2);
    n_checks++;
    if (!(ok && ok2) || wr_addr_m[base] !== 18'd76800) begin
      n_fail++; $display("FAIL midrst_first got %0d want 76800", wr_addr_m[base]);
    end
    for (int n = 0; n < 64; n++) begin
      n_checks++;
      if (wr_data_m[base+n] !== exp_d[n]) begin
        n_fail++;
        $display("FAIL midrst_word%0d got %h want %h", n, wr_data_m[base+n], exp_d[n]);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dequant_q0();
    test_q1();
    test_saturation();
    test_block_addressing();
    test_segments();
    test_backpressure();
    test_reset_midblock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
